// File: rtl/fetch_seq.sv
// Purpose: instruction fetch sequencer; pulls opcode plus up to two operands from memory and hands them to execute.
// Latency: 1- and 2-byte instructions are VALID two cycles after the opcode fetch starts, 3-byte after three.
// Backpressure: RDY=0 or CO=1 stalls the current fetch; HOLD keeps the instruction until DONE.
module fetch_seq #(
  parameter logic [7:0] IR_RESET    = 8'hEA,
  parameter logic [1:0] LEN_DEFAULT = 2'd1
) (
  input  logic        CLK,
  input  logic        R,
  input  logic [15:0] PC,
  input  logic        CO,
  input  logic [7:0]  DB,
  input  logic        RDY,
  input  logic [1:0]  LEN,
  input  logic        DONE,
  input  logic        JMP,
  input  logic [15:0] JMP_ADDR,
  output logic [15:0] AB,
  output logic        INC,
  output logic        WR,
  output logic [7:0]  HI,
  output logic [7:0]  LO,
  output logic        CI,
  output logic        SYNC,
  output logic [7:0]  IR,
  output logic [7:0]  OPL,
  output logic [7:0]  OPH,
  output logic        VALID
);

  typedef enum logic [1:0] {
    ST_OPC  = 2'd0,
    ST_OP1  = 2'd1,
    ST_OP2  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       fetch_ok;
  logic [1:0] eff_len;
  logic       cap_ir;
  logic       cap_opl;
  logic       cap_oph;

  // The PC drives the address bus directly; no carry-in is ever used on a load.
  assign AB = PC;
  assign CI = 1'b0;

  // A byte can only be taken when memory is ready and the PC high byte is current.
  assign fetch_ok = RDY & ~CO;
  assign eff_len  = (LEN == 2'd0) ? LEN_DEFAULT : LEN;

  // State register and instruction capture; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (R) begin
      state <= ST_OPC;
      IR    <= IR_RESET;
      OPL   <= 8'h00;
      OPH   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (cap_ir) begin
        IR  <= DB;
        OPL <= 8'h00;
        OPH <= 8'h00;
      end
      if (cap_opl) OPL <= DB;
      if (cap_oph) OPH <= DB;
    end
  end

  // Next-state and per-cycle strobes; INC is raised exactly when a byte is latched.
  always_comb begin
    state_nxt = state;
    INC       = 1'b0;
    WR        = 1'b0;
    HI        = 8'h00;
    LO        = 8'h00;
    SYNC      = 1'b0;
    VALID     = 1'b0;
    cap_ir    = 1'b0;
    cap_opl   = 1'b0;
    cap_oph   = 1'b0;
    case (state)
      ST_OPC: begin
        SYNC = 1'b1;
        if (fetch_ok) begin
          INC       = 1'b1;
          cap_ir    = 1'b1;
          state_nxt = ST_OP1;
        end
      end
      ST_OP1: begin
        // Single-byte opcodes spend this cycle as a decode bubble with no fetch.
        if (eff_len == 2'd1) begin
          state_nxt = ST_HOLD;
        end else if (fetch_ok) begin
          INC       = 1'b1;
          cap_opl   = 1'b1;
          state_nxt = (eff_len == 2'd3) ? ST_OP2 : ST_HOLD;
        end
      end
      ST_OP2: begin
        if (fetch_ok) begin
          INC       = 1'b1;
          cap_oph   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        VALID = 1'b1;
        if (DONE) begin
          state_nxt = ST_OPC;
          if (JMP) begin
            WR = 1'b1;
            HI = JMP_ADDR[15:8];
            LO = JMP_ADDR[7:0];
          end
        end
      end
      default: state_nxt = ST_OPC;
    endcase
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: PC and memory models around the DUT, directed instruction sequences.
// Expected values are hand-derived per cycle from the instruction bytes and lengths.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_fetch_seq;

  logic        CLK = 1'b0;
  logic        R;
  logic [15:0] PC;
  logic        CO;
  logic [7:0]  DB;
  logic        RDY;
  logic [1:0]  LEN;
  logic        DONE;
  logic        JMP;
  logic [15:0] JMP_ADDR;
  logic [15:0] AB;
  logic        INC;
  logic        WR;
  logic [7:0]  HI;
  logic [7:0]  LO;
  logic        CI;
  logic        SYNC;
  logic [7:0]  IR;
  logic [7:0]  OPL;
  logic [7:0]  OPH;
  logic        VALID;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc_q;
  logic        co_q;
  logic        tb_load;
  logic [15:0] tb_addr;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_seq dut (
    .CLK(CLK), .R(R), .PC(PC), .CO(CO), .DB(DB), .RDY(RDY), .LEN(LEN),
    .DONE(DONE), .JMP(JMP), .JMP_ADDR(JMP_ADDR), .AB(AB), .INC(INC),
    .WR(WR), .HI(HI), .LO(LO), .CI(CI), .SYNC(SYNC), .IR(IR), .OPL(OPL),
    .OPH(OPH), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  // Decoder length table; opcode 00 reports 0 to exercise the default length.
  function automatic logic [1:0] len_of(input logic [7:0] op);
    case (op)
      8'hA9:   return 2'd2;
      8'h4C:   return 2'd3;
      8'h00:   return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  assign LEN = len_of(IR);
  assign DB  = mem[AB];
  assign PC  = pc_q;
  assign CO  = co_q;

  // PC model: low byte increments first, high byte follows a cycle later on wrap.
  always @(posedge CLK) begin
    if (tb_load) begin
      pc_q <= tb_addr;
      co_q <= 1'b0;
    end else if (WR) begin
      pc_q <= {HI, LO};
      co_q <= 1'b0;
    end else if (co_q) begin
      pc_q[15:8] <= pc_q[15:8] + 8'd1;
      co_q       <= 1'b0;
    end else if (INC) begin
      pc_q[7:0] <= pc_q[7:0] + 8'd1;
      if (pc_q[7:0] == 8'hFF) co_q <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge CLK);
    #1;
  endtask

  // Reset the DUT and load the PC; returns at the sample point of the first fetch cycle.
  task automatic reset_to(input logic [15:0] addr);
    @(negedge CLK);
    R = 1'b1; tb_load = 1'b1; tb_addr = addr;
    @(negedge CLK);
    R = 1'b0; tb_load = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h42; mem[16'h0002] = 8'hEA;
    mem[16'h0010] = 8'h4C; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    mem[16'h1234] = 8'hEA;
    mem[16'h0020] = 8'hEA;
    mem[16'h0050] = 8'h00;
    mem[16'h00FF] = 8'hA9; mem[16'h0100] = 8'h77;
    mem[16'h0030] = 8'hA9; mem[16'h0031] = 8'h55;
    mem[16'h0040] = 8'h4C; mem[16'h0041] = 8'h11; mem[16'h0042] = 8'h22;

    R = 1'b1; RDY = 1'b0; DONE = 1'b1; JMP = 1'b0; JMP_ADDR = 16'h0000;
    tb_load = 1'b1; tb_addr = 16'h0000;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_valid", VALID, 0);
    check("rst_ir",    IR, 16'h00EA);
    check("rst_opl",   OPL, 0);
    check("rst_oph",   OPH, 0);
    check("rst_inc",   INC, 0);
    check("rst_wr",    WR, 0);
    check("rst_ci",    CI, 0);

    // 2-byte A9 42 at 0000
    @(negedge CLK);
    R = 1'b0; tb_load = 1'b0; RDY = 1'b1;
    #1;
    check("t1_sync", SYNC, 1);
    check("t1_ab0",  AB, 16'h0000);
    check("t1_inc0", INC, 1);
    next_cycle();
    check("t1_ab1",  AB, 16'h0001);
    check("t1_inc1", INC, 1);
    check("t1_sync1", SYNC, 0);
    next_cycle();
    check("t1_valid", VALID, 1);
    check("t1_ir",   IR, 16'h00A9);
    check("t1_opl",  OPL, 16'h0042);
    check("t1_oph",  OPH, 0);
    check("t1_inch", INC, 0);
    next_cycle();
    check("t1_nvalid", VALID, 0);
    check("t1_nsync", SYNC, 1);
    check("t1_nab",  AB, 16'h0002);

    // 3-byte jump 4C 34 12 at 0010
    JMP = 1'b1; JMP_ADDR = 16'h1234;
    reset_to(16'h0010);
    check("t2_inc0", INC, 1);
    next_cycle();
    check("t2_ab1", AB, 16'h0011);
    next_cycle();
    check("t2_ab2",  AB, 16'h0012);
    check("t2_inc2", INC, 1);
    check("t2_wr2",  WR, 0);
    next_cycle();
    check("t2_valid", VALID, 1);
    check("t2_opl",  OPL, 16'h0034);
    check("t2_oph",  OPH, 16'h0012);
    check("t2_wr",   WR, 1);
    check("t2_hilo", {HI, LO}, 16'h1234);
    check("t2_inc",  INC, 0);
    check("t2_ci",   CI, 0);
    next_cycle();
    check("t2_wr_off", WR, 0);
    check("t2_sync", SYNC, 1);
    check("t2_ab",   AB, 16'h1234);
    JMP = 1'b0;

    // 1-byte EA at 0020
    reset_to(16'h0020);
    check("t3_inc0", INC, 1);
    next_cycle();
    check("t3_bubble", INC, 0);
    check("t3_ab1",  AB, 16'h0021);
    next_cycle();
    check("t3_valid", VALID, 1);
    check("t3_ir",   IR, 16'h00EA);
    next_cycle();
    check("t3_sync", SYNC, 1);
    check("t3_ab",   AB, 16'h0021);

    // LEN=0 falls back to the default length of 1
    reset_to(16'h0050);
    next_cycle();
    check("t3d_bubble", INC, 0);
    next_cycle();
    check("t3d_valid", VALID, 1);
    check("t3d_ir",  IR, 16'h0000);

    // Opcode at 00FF: carry stall before the operand at 0100
    reset_to(16'h00FF);
    check("t4_inc0", INC, 1);
    next_cycle();
    check("t4_ab_stale", AB, 16'h0000);
    check("t4_co",   CO, 1);
    check("t4_stall", INC, 0);
    next_cycle();
    check("t4_ab",   AB, 16'h0100);
    check("t4_inc",  INC, 1);
    next_cycle();
    check("t4_valid", VALID, 1);
    check("t4_opl",  OPL, 16'h0077);

    // RDY low for 3 cycles during OP1
    reset_to(16'h0030);
    @(negedge CLK);
    RDY = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t5_inc_wait", INC, 0);
      check("t5_ab_wait", AB, 16'h0031);
      if (i < 2) next_cycle();
    end
    @(negedge CLK);
    RDY = 1'b1;
    #1;
    check("t5_inc", INC, 1);
    check("t5_opl_pre", OPL, 0);
    next_cycle();
    check("t5_valid", VALID, 1);
    check("t5_opl", OPL, 16'h0055);

    // Reset in OP2
    DONE = 1'b0;
    reset_to(16'h0040);
    next_cycle();
    @(negedge CLK);
    R = 1'b1;
    @(negedge CLK);
    #1;
    check("t6_rst_valid", VALID, 0);
    check("t6_rst_ir",  IR, 16'h00EA);
    check("t6_rst_opl", OPL, 0);
    check("t6_rst_sync", SYNC, 1);
    R = 1'b0;

    // HOLD persists with DONE=0, JMP ignored
    JMP = 1'b1; JMP_ADDR = 16'h5555;
    reset_to(16'h0040);
    repeat (3) next_cycle();
    for (int i = 0; i < 3; i++) begin
      check("t6_valid", VALID, 1);
      check("t6_ir",  IR, 16'h004C);
      check("t6_ops", {OPH, OPL}, 16'h2211);
      check("t6_inc", INC, 0);
      check("t6_wr",  WR, 0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
